// File: rtl/host_mst_txn_limiter.sv
// host_mst_txn_limiter
// Caps outstanding AXI write/read transactions toward the host port and lets
// software quiesce host traffic via flush_i. Only the AW/AR handshakes are
// gated; every payload field and the W/B/R channels pass straight through.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             level; while high no new AW/AR is started
//   slv_req_i/resp_o    upstream side (from master mux / ID remap)
//   mst_req_o/resp_i    host side
//   wr_outstanding_o    writes with AW accepted and B not yet accepted
//   rd_outstanding_o    reads with AR accepted and last R not yet accepted
//   idle_o              both counts zero and no AW/AR valid downstream

package host_mst_txn_limiter_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } axi_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        r_t   r;
        logic r_valid;
    } axi_resp_t;
endpackage

module host_mst_txn_limiter #(
    parameter int unsigned MaxWrTxns  = 8,
    parameter int unsigned MaxRdTxns  = 8,
    parameter type         req_t      = host_mst_txn_limiter_pkg::axi_req_t,
    parameter type         resp_t     = host_mst_txn_limiter_pkg::axi_resp_t,
    parameter int unsigned WrCntWidth = $clog2(MaxWrTxns + 1),
    parameter int unsigned RdCntWidth = $clog2(MaxRdTxns + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  req_t                  slv_req_i,
    output resp_t                 slv_resp_o,
    output req_t                  mst_req_o,
    input  resp_t                 mst_resp_i,
    output logic [WrCntWidth-1:0] wr_outstanding_o,
    output logic [RdCntWidth-1:0] rd_outstanding_o,
    output logic                  idle_o
);

    logic [WrCntWidth-1:0] wr_cnt;
    logic [RdCntWidth-1:0] rd_cnt;
    logic                  aw_hold, ar_hold;
    logic                  aw_pass, ar_pass;
    logic                  aw_hs, ar_hs, b_hs, r_last_hs;

    // A held valid keeps its pass even if flush_i rises or the count moves,
    // so an AW/AR once shown to the host is never withdrawn.
    assign aw_pass = ((wr_cnt != WrCntWidth'(MaxWrTxns)) & ~flush_i) | aw_hold;
    assign ar_pass = ((rd_cnt != RdCntWidth'(MaxRdTxns)) & ~flush_i) | ar_hold;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_pass;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_pass;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_pass;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_pass;
    end

    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    // Hold is set while a presented AW/AR is stalled and drops on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_hold <= 1'b0;
            ar_hold <= 1'b0;
        end else begin
            aw_hold <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
            ar_hold <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
        end
    end

    // Registered counters: a freed slot is usable from the next cycle only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   wr_cnt <= wr_cnt + WrCntWidth'(1);
                2'b01:   wr_cnt <= wr_cnt - WrCntWidth'(1);
                default: wr_cnt <= wr_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt <= '0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   rd_cnt <= rd_cnt + RdCntWidth'(1);
                2'b01:   rd_cnt <= rd_cnt - RdCntWidth'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    assign wr_outstanding_o = wr_cnt;
    assign rd_outstanding_o = rd_cnt;
    assign idle_o = (wr_cnt == '0) & (rd_cnt == '0) &
                    ~mst_req_o.aw_valid & ~mst_req_o.ar_valid;

`ifndef SYNTHESIS
    // A response with nothing outstanding is a host protocol error.
    a_no_b_at_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_hs |-> (wr_cnt != '0));
    a_no_r_at_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_last_hs |-> (rd_cnt != '0));
    a_no_aw_at_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        aw_hs |-> (wr_cnt != WrCntWidth'(MaxWrTxns)));
    a_no_ar_at_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ar_hs |-> (rd_cnt != RdCntWidth'(MaxRdTxns)));
`endif

endmodule

// File: tb/tb_host_mst_txn_limiter.sv
module tb_host_mst_txn_limiter;
    import host_mst_txn_limiter_pkg::*;

    localparam int unsigned MaxWr = 2;
    localparam int unsigned MaxRd = 2;
    localparam int unsigned WrW   = $clog2(MaxWr + 1);
    localparam int unsigned RdW   = $clog2(MaxRd + 1);
    localparam logic [31:0] AwAddr = 32'h1234_5678;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    axi_req_t        slv_req, mst_req;
    axi_resp_t       slv_resp, mst_resp;
    logic [WrW-1:0]  wr_out;
    logic [RdW-1:0]  rd_out;
    logic            idle;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    host_mst_txn_limiter #(.MaxWrTxns(MaxWr), .MaxRdTxns(MaxRd)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out), .idle_o(idle)
    );

    // in:  {flush, aw_valid, ar_valid, aw_ready, ar_ready, b_valid, b_ready,
    //       r_valid, r_ready, r_last}
    // hs:  {mst aw_valid, slv aw_ready, mst ar_valid, slv ar_ready}
    typedef struct {
        logic [9:0] in;
        logic [3:0] hs;
        int         wr;
        int         rd;
        logic       idle;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [9:0] in, logic [3:0] hs, int wr, int rd,
                                logic id, string tag);
        vec_t v;
        v.in = in; v.hs = hs; v.wr = wr; v.rd = rd; v.idle = id; v.tag = tag;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [9:0] in);
        flush                 = in[9];
        slv_req.aw_valid      = in[8];
        slv_req.ar_valid      = in[7];
        mst_resp.aw_ready     = in[6];
        mst_resp.ar_ready     = in[5];
        mst_resp.b_valid      = in[4];
        slv_req.b_ready       = in[3];
        mst_resp.r_valid      = in[2];
        slv_req.r_ready       = in[1];
        mst_resp.r.last       = in[0];
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v.in);
        #1;
        chk({v.tag, ".mst_aw_valid"}, 64'(mst_req.aw_valid),  64'(v.hs[3]));
        chk({v.tag, ".slv_aw_ready"}, 64'(slv_resp.aw_ready), 64'(v.hs[2]));
        chk({v.tag, ".mst_ar_valid"}, 64'(mst_req.ar_valid),  64'(v.hs[1]));
        chk({v.tag, ".slv_ar_ready"}, 64'(slv_resp.ar_ready), 64'(v.hs[0]));
        chk({v.tag, ".wr_out"}, 64'(wr_out), 64'(v.wr));
        chk({v.tag, ".rd_out"}, 64'(rd_out), 64'(v.rd));
        chk({v.tag, ".idle"},   64'(idle),   64'(v.idle));
        if (v.hs[3])
            chk({v.tag, ".aw_addr"}, 64'(mst_req.aw.addr), 64'(AwAddr));
    endtask

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        flush    = 1'b0;
        slv_req.aw.addr = AwAddr;
        slv_req.aw.id   = 4'h3;
        slv_req.ar.addr = 32'hCAFE_0000;
        rst_n = 1'b0;
        #12;
        chk("reset.wr_out", 64'(wr_out), 64'd0);
        chk("reset.rd_out", 64'(rd_out), 64'd0);
        chk("reset.idle",   64'(idle),   64'd1);
        rst_n = 1'b1;

        // write limit, no-bypass latency, simultaneous AW+B
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "w0"));
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b1100, 0, 0, 0, "w1"));
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b1100, 1, 0, 0, "w2"));
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b0000, 2, 0, 0, "w3_full"));
        vecs.push_back(mk(10'b0_1_0_1_0_1_1_0_0_0, 4'b0000, 2, 0, 0, "w4_b_nobypass"));
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b1100, 1, 0, 0, "w5_reissue"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 2, 0, 0, "w6"));
        vecs.push_back(mk(10'b0_0_0_0_0_1_1_0_0_0, 4'b0000, 2, 0, 0, "w7_b"));
        vecs.push_back(mk(10'b0_1_0_1_0_1_1_0_0_0, 4'b1100, 1, 0, 0, "w8_aw_and_b"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 1, 0, 0, "w9_same"));
        vecs.push_back(mk(10'b0_0_0_0_0_1_1_0_0_0, 4'b0000, 1, 0, 0, "w10_b"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "w11"));
        // read limit with 4-beat bursts; only last beat decrements
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_0_0_0, 4'b0011, 0, 0, 0, "r1"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_0_0_0, 4'b0011, 0, 1, 0, "r2"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_1_1_0, 4'b0000, 0, 2, 0, "r_beat1"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_1_1_0, 4'b0000, 0, 2, 0, "r_beat2"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_1_1_0, 4'b0000, 0, 2, 0, "r_beat3"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_1_1_1, 4'b0000, 0, 2, 0, "r_beat4"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_1_0, 4'b0000, 0, 1, 0, "r_beat5"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_1_0, 4'b0000, 0, 1, 0, "r_beat6"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_1_0, 4'b0000, 0, 1, 0, "r_beat7"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_1_1, 4'b0000, 0, 1, 0, "r_beat8"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "r_done"));
        // stalled AW survives a flush, then flush blocks new AWs
        vecs.push_back(mk(10'b0_1_0_0_0_0_0_0_0_0, 4'b1000, 0, 0, 0, "h1_stall"));
        vecs.push_back(mk(10'b1_1_0_0_0_0_0_0_0_0, 4'b1000, 0, 0, 0, "h2_flush_hold"));
        vecs.push_back(mk(10'b1_1_0_1_0_0_0_0_0_0, 4'b1100, 0, 0, 0, "h3_accept"));
        vecs.push_back(mk(10'b1_1_0_1_0_0_0_0_0_0, 4'b0000, 1, 0, 0, "h4_blocked"));
        vecs.push_back(mk(10'b1_0_0_0_0_1_1_0_0_0, 4'b0000, 1, 0, 0, "h5_b"));
        vecs.push_back(mk(10'b1_1_0_1_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "h6_idle"));
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b1100, 0, 0, 0, "h7_resume"));
        vecs.push_back(mk(10'b0_0_0_0_0_1_1_0_0_0, 4'b0000, 1, 0, 0, "h8_b"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "h9"));
        // flush with writes and reads in flight; responses drain it
        vecs.push_back(mk(10'b0_1_0_1_0_0_0_0_0_0, 4'b1100, 0, 0, 0, "f1_aw"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_0_0_0, 4'b0011, 1, 0, 0, "f2_ar"));
        vecs.push_back(mk(10'b1_1_1_1_1_0_0_0_0_0, 4'b0000, 1, 1, 0, "f3_blocked"));
        vecs.push_back(mk(10'b1_0_1_0_1_1_1_0_0_0, 4'b0000, 1, 1, 0, "f4_b"));
        vecs.push_back(mk(10'b1_0_1_0_1_0_0_1_1_1, 4'b0000, 0, 1, 0, "f5_rlast"));
        vecs.push_back(mk(10'b1_0_1_0_1_0_0_0_0_0, 4'b0000, 0, 0, 1, "f6_idle"));
        vecs.push_back(mk(10'b0_0_1_0_1_0_0_0_0_0, 4'b0011, 0, 0, 0, "f7_resume_ar"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_1_1, 4'b0000, 0, 1, 0, "f8_rlast"));
        vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 1, "f9"));

        foreach (vecs[i]) apply(vecs[i]);

        // W/B/R pass-through is unaffected by flush
        @(negedge clk);
        drive(10'b1_0_0_0_0_1_0_1_0_0);
        slv_req.w_valid   = 1'b1;
        slv_req.w.data    = 32'hDEAD_BEEF;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b.id     = 4'h5;
        mst_resp.r.data   = 32'h0BAD_F00D;
        #1;
        chk("pt.w_valid", 64'(mst_req.w_valid),   64'd1);
        chk("pt.w_data",  64'(mst_req.w.data),    64'hDEAD_BEEF);
        chk("pt.w_ready", 64'(slv_resp.w_ready),  64'd1);
        chk("pt.b_valid", 64'(slv_resp.b_valid),  64'd1);
        chk("pt.b_id",    64'(slv_resp.b.id),     64'h5);
        chk("pt.r_data",  64'(slv_resp.r.data),   64'h0BAD_F00D);
        slv_req.w_valid  = 1'b0;
        mst_resp.w_ready = 1'b0;

        // fill to 2/2 then reset asynchronously mid-cycle
        @(negedge clk);
        drive(10'b0_1_1_1_1_0_0_0_0_0);
        @(negedge clk);
        @(negedge clk);
        drive(10'b0_0_0_0_0_0_0_0_0_0);
        #1;
        chk("full.wr_out", 64'(wr_out), 64'd2);
        chk("full.rd_out", 64'(rd_out), 64'd2);
        chk("full.idle",   64'(idle),   64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst.wr_out", 64'(wr_out), 64'd0);
        chk("async_rst.rd_out", 64'(rd_out), 64'd0);
        chk("async_rst.idle",   64'(idle),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
